norm_shift_32: RTL and testbench

NORM_SHIFT_32 -- requirements
Module: norm_shift_32

---
 rtl/norm_shift_32_pkg.sv | 15 +
 rtl/LZC_32.sv | 19 +
 rtl/norm_shift_32.sv | 91 +++++++++
 tb/tb_norm_shift_32.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/norm_shift_32_pkg.sv
// norm_shift_32_pkg: shared widths and pipeline valid-control encoding for the normalizer
package norm_shift_32_pkg;

    localparam int DATA_W    = 32;
    localparam int LZ_W      = 5;
    localparam int EXP_GUARD = 2;

    typedef struct packed {
        logic s1;
        logic s2;
    } vld_t;

    localparam vld_t VLD_EMPTY = '{s1: 1'b0, s2: 1'b0};

endpackage

// File: rtl/LZC_32.sv
// LZC_32: leading-zero count of a 32-bit word plus an all-zero flag
module LZC_32
    import norm_shift_32_pkg::*;
(
    input  logic [DATA_W-1:0] data,
    output logic [LZ_W-1:0]   count,
    output logic              zero
);

    // The highest set bit is visited last, so it determines the count.
    always_comb begin
        count = '0;
        for (int i = 0; i < DATA_W; i++)
            if (data[i]) count = LZ_W'(DATA_W - 1 - i);
    end

    assign zero = ~|data;

endmodule

// File: rtl/norm_shift_32.sv
// norm_shift_32: two-stage valid/ready left normalizer with exponent adjust
module norm_shift_32
    import norm_shift_32_pkg::*;
#(
    parameter int EXP_W = 8
) (
    input  logic                       CLK,
    input  logic                       RESET_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [DATA_W-1:0]          In,
    input  logic [EXP_W-1:0]           Exp_in,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [DATA_W-1:0]          Out,
    output logic [EXP_W+EXP_GUARD-1:0] Exp_out,
    output logic [LZ_W-1:0]            Shift,
    output logic                       Zero,
    output logic                       Underflow
);

    localparam int EW = EXP_W + EXP_GUARD;

    vld_t              vld;
    logic              s1_take, s2_take;
    logic [LZ_W-1:0]   lz;
    logic              all_zero;
    logic [DATA_W-1:0] s1_data;
    logic [EXP_W-1:0]  s1_exp;
    logic [LZ_W-1:0]   s1_lz;
    logic              s1_zero;
    logic [DATA_W-1:0] lvl [LZ_W+1];
    logic [EW-1:0]     exp_adj;
    logic              exp_low;

    assign s2_take   = !vld.s2 | out_ready;
    assign s1_take   = !vld.s1 | s2_take;
    assign in_ready  = s1_take;
    assign out_valid = vld.s2;

    LZC_32 u_lzc (
        .data  (In),
        .count (lz),
        .zero  (all_zero)
    );

    assign lvl[0] = s1_data;
    for (genvar i = 0; i < LZ_W; i++) begin : g_shift
        assign lvl[i+1] = s1_lz[i] ? lvl[i] << (1 << i) : lvl[i];
    end

    // Guard bits make the difference a signed value that cannot wrap.
    assign exp_adj = {{EXP_GUARD{1'b0}}, s1_exp} - {{(EW-LZ_W){1'b0}}, s1_lz};
    assign exp_low = exp_adj[EW-1] | ~|exp_adj;

    always_ff @(posedge CLK or negedge RESET_n) begin
        if (!RESET_n) begin
            vld       <= VLD_EMPTY;
            s1_data   <= '0;
            s1_exp    <= '0;
            s1_lz     <= '0;
            s1_zero   <= 1'b0;
            Out       <= '0;
            Exp_out   <= '0;
            Shift     <= '0;
            Zero      <= 1'b0;
            Underflow <= 1'b0;
        end else begin
            if (s1_take) begin
                vld.s1 <= in_valid;
                if (in_valid) begin
                    s1_data <= In;
                    s1_exp  <= Exp_in;
                    s1_lz   <= lz;
                    s1_zero <= all_zero;
                end
            end
            if (s2_take) begin
                vld.s2 <= vld.s1;
                if (vld.s1) begin
                    Out       <= lvl[LZ_W];
                    Exp_out   <= s1_zero ? '0 : exp_adj;
                    Shift     <= s1_zero ? '0 : s1_lz;
                    Zero      <= s1_zero;
                    Underflow <= !s1_zero && exp_low;
                end
            end
        end
    end

endmodule

// File: tb/tb_norm_shift_32.sv
// tb_norm_shift_32: directed self-checking bench for norm_shift_32
module tb_norm_shift_32;

    logic        CLK = 1'b0;
    logic        RESET_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] In = '0;
    logic [7:0]  Exp_in = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] Out;
    logic [9:0]  Exp_out;
    logic [4:0]  Shift;
    logic        Zero;
    logic        Underflow;

    int n_cmp = 0;
    int n_err = 0;

    norm_shift_32 #(.EXP_W(8)) dut (
        .CLK       (CLK),
        .RESET_n   (RESET_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .In        (In),
        .Exp_in    (Exp_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .Out       (Out),
        .Exp_out   (Exp_out),
        .Shift     (Shift),
        .Zero      (Zero),
        .Underflow (Underflow)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, got, want);
        end
    endtask

    task automatic run_one(input string tag, input logic [31:0] d, input logic [7:0] e,
                           input logic [31:0] w_out, input logic [9:0] w_exp,
                           input logic [4:0] w_sh, input logic w_z, input logic w_uf);
        in_valid = 1'b1;
        In       = d;
        Exp_in   = e;
        #1;
        check({tag, ".in_ready"}, in_ready, 1);
        @(posedge CLK); #1;
        in_valid = 1'b0;
        check({tag, ".early"}, out_valid, 0);
        @(posedge CLK); #1;
        check({tag, ".valid"}, out_valid, 1);
        check({tag, ".out"}, Out, w_out);
        check({tag, ".exp"}, Exp_out, w_exp);
        check({tag, ".shift"}, Shift, w_sh);
        check({tag, ".zero"}, Zero, w_z);
        check({tag, ".uf"}, Underflow, w_uf);
        @(posedge CLK); #1;
        check({tag, ".drop"}, out_valid, 0);
    endtask

    logic [31:0] s_in  [4] = '{32'h1234_5678, 32'h00AB_CDEF, 32'h0000_0F00, 32'h7FFF_FFFF};
    logic [31:0] s_out [4] = '{32'h91A2_B3C0, 32'hABCD_EF00, 32'hF000_0000, 32'hFFFF_FFFE};
    logic [4:0]  s_sh  [4] = '{5'd3, 5'd8, 5'd20, 5'd1};
    logic [9:0]  s_exp [4] = '{10'd97, 10'd92, 10'd80, 10'd99};

    initial begin
        int idx;
        int got;
        logic acc;
        #1;
        check("rst.out_valid", out_valid, 0);
        check("rst.in_ready", in_ready, 1);
        check("rst.out", Out, 0);
        check("rst.exp", Exp_out, 0);
        @(negedge CLK);
        RESET_n = 1'b1;
        @(posedge CLK); #1;

        run_one("v16",  32'h0001_0000, 8'd20,  32'h8000_0000, 10'd5,     5'd15, 1'b0, 1'b0);
        run_one("v1",   32'h0000_0001, 8'd31,  32'h8000_0000, 10'd0,     5'd31, 1'b0, 1'b1);
        run_one("vz",   32'h0000_0000, 8'd100, 32'h0000_0000, 10'd0,     5'd0,  1'b1, 1'b0);
        run_one("vtop", 32'hC000_0000, 8'd1,   32'hC000_0000, 10'd1,     5'd0,  1'b0, 1'b0);
        run_one("vneg", 32'h0000_0003, 8'd10,  32'hC000_0000, 10'h3EC,   5'd30, 1'b0, 1'b1);
        run_one("vedge",32'h00F0_0000, 8'd8,   32'hF000_0000, 10'd0,     5'd8,  1'b0, 1'b1);
        run_one("vpos1",32'h00F0_0000, 8'd9,   32'hF000_0000, 10'd1,     5'd8,  1'b0, 1'b0);

        idx = 0;
        got = 0;
        for (int c = 0; c < 12; c++) begin
            out_ready = !(c >= 2 && c <= 4);
            in_valid  = idx < 4;
            if (idx < 4) begin
                In     = s_in[idx];
                Exp_in = 8'd100;
            end
            #1;
            if (c >= 2 && c <= 4) begin
                check($sformatf("stall.in_ready.c%0d", c), in_ready, 0);
                check($sformatf("stall.valid.c%0d", c), out_valid, 1);
                check($sformatf("stall.hold_out.c%0d", c), Out, s_out[0]);
                check($sformatf("stall.hold_sh.c%0d", c), Shift, s_sh[0]);
            end
            if (out_valid && out_ready) begin
                if (got < 4) begin
                    check($sformatf("stream.out%0d", got), Out, s_out[got]);
                    check($sformatf("stream.sh%0d", got), Shift, s_sh[got]);
                    check($sformatf("stream.exp%0d", got), Exp_out, s_exp[got]);
                end
                got++;
            end
            acc = in_valid && in_ready;
            @(posedge CLK); #1;
            if (acc) idx++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        check("stream.accepted", idx, 4);
        check("stream.delivered", got, 4);

        in_valid = 1'b1;
        In       = 32'h1234_5678;
        Exp_in   = 8'd50;
        @(posedge CLK); #1;
        In = 32'h00AB_CDEF;
        @(posedge CLK); #1;
        in_valid = 1'b0;
        check("rst_mid.pre_valid", out_valid, 1);
        #2;
        RESET_n = 1'b0;
        #1;
        check("rst_mid.valid", out_valid, 0);
        check("rst_mid.out", Out, 0);
        check("rst_mid.shift", Shift, 0);
        check("rst_mid.in_ready", in_ready, 1);
        @(negedge CLK);
        RESET_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(posedge CLK); #1;
            check($sformatf("rst_mid.quiet%0d", c), out_valid, 0);
        end
        run_one("post_rst", 32'h0001_0000, 8'd20, 32'h8000_0000, 10'd5, 5'd15, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
